vme_bus_arbiter: RTL and testbench

- Slot-1 VME bus arbiter for the system controller CPLD.
- Accepts the four active-low bus requests BR0..BR3 and drives one active-low bus grant per level.
- Tracks bus ownership through BBSY and requests early release through BCLR.
- Replaces the ad-hoc grant logic in the system board top level; the top level instantiates it and wires pins straight through.

---
 rtl/vme_arb_pkg.sv | 62 ++++++
 rtl/vme_sync.sv | 31 +++
 rtl/vme_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_vme_bus_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vme_arb_pkg.sv
// Shared types, pin polarity constants and level-selection helpers for the
// slot-1 VME bus arbiter.
package vme_arb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GRANT  = 3'd1,
      BUSY   = 3'd2,
      CLEAR  = 3'd3,
      SETTLE = 3'd4
   } arb_state_t;

   // Backplane signals are active low.
   localparam logic ACTIVE   = 1'b0;
   localparam logic INACTIVE = 1'b1;
   localparam logic [3:0] NO_REQUEST = 4'b1111;

   // Picks the level to grant from the synchronised requests.
   // Priority mode: highest active level wins (BR3 highest).
   // Round-robin mode: first active level searching downward from
   // last_owner-1, wrapping 0->3; the previous owner is considered last.
   function automatic logic [1:0] select_level(input logic [3:0] br,
                                               input logic [1:0] last_owner,
                                               input logic       rr_mode);
      logic [1:0] level;
      logic [1:0] idx;
      logic       found;
      level = 2'd0;
      idx   = 2'd0;
      found = 1'b0;
      if (rr_mode) begin
         for (int i = 1; i <= 4; i++) begin
            idx = last_owner - 2'(i);
            if (!found && br[idx] == ACTIVE) begin
               level = idx;
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (br[i] == ACTIVE) begin
               level = 2'(i);
            end
         end
      end
      return level;
   endfunction

   // True when some level above the current owner is requesting the bus.
   function automatic logic higher_request(input logic [3:0] br,
                                           input logic [1:0] level);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(level) && br[i] == ACTIVE) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/vme_sync.sv
// Multi-flop input synchronizer; flops preset to 1 so a reset leaves every
// active-low backplane input looking inactive.
module vme_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] stage [STAGES];

   // Shift the pin value through the synchronizer chain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '1;
         end
      end else begin
         stage[0] <= async_in;
         for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign sync_out = stage[STAGES-1];

endmodule

// File: rtl/vme_bus_arbiter.sv
// Slot-1 VME bus arbiter: four-level BR/BG arbitration with BBSY tracking,
// BCLR early-release requests and a grant timeout.
// Build option: define VME_ARB_ROUND_ROBIN_EN for round-robin level selection
// (BCLR is then never driven); default is fixed priority with BR3 highest.
module vme_bus_arbiter #(
   parameter int GRANT_TIMEOUT = 255,
   parameter int SETTLE_CYCLES = 2,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] vme_br,
   input  logic       vme_bbsy,
   output logic [3:0] vme_bgout,
   output logic       vme_bclr,
   output logic [1:0] arb_owner,
   output logic       arb_busy,
   output logic       grant_timeout
);

   import vme_arb_pkg::*;

`ifdef VME_ARB_ROUND_ROBIN_EN
   localparam logic RR_MODE = 1'b1;
`else
   localparam logic RR_MODE = 1'b0;
`endif

   // The counter value on the last cycle of a grant window / settle window.
   localparam logic [7:0] TIMEOUT_LAST = 8'(GRANT_TIMEOUT - 1);
   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);

   arb_state_t state, state_next;
   logic [3:0] br_s;
   logic       bbsy_s;
   logic [7:0] cnt, cnt_next;
   logic [3:0] bgout_next;
   logic       bclr_next;
   logic [1:0] owner_next;
   logic       timeout_next;
   logic [1:0] sel_level;
   logic       clear_req;

   vme_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_br_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (vme_br),
      .sync_out (br_s)
   );

   vme_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_bbsy_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (vme_bbsy),
      .sync_out (bbsy_s)
   );

   assign sel_level = select_level(br_s, arb_owner, RR_MODE);
   assign clear_req = RR_MODE ? 1'b0 : higher_request(br_s, arb_owner);
   assign arb_busy  = (state != IDLE);

   // Register state, the shared cycle counter and all bus-facing outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         vme_bgout     <= NO_REQUEST;
         vme_bclr      <= INACTIVE;
         arb_owner     <= 2'd0;
         grant_timeout <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         vme_bgout     <= bgout_next;
         vme_bclr      <= bclr_next;
         arb_owner     <= owner_next;
         grant_timeout <= timeout_next;
      end
   end

   // Next-state and next-output decode; bbsy_s is checked first in GRANT and
   // BUSY so a bus takeover always beats a timeout or a clear request.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bgout_next   = vme_bgout;
      bclr_next    = vme_bclr;
      owner_next   = arb_owner;
      timeout_next = 1'b0;
      case (state)
         IDLE: begin
            if (br_s != NO_REQUEST && bbsy_s == INACTIVE) begin
               state_next            = GRANT;
               bgout_next            = NO_REQUEST;
               bgout_next[sel_level] = ACTIVE;
               owner_next            = sel_level;
               cnt_next              = 8'd0;
            end
         end
         GRANT: begin
            if (bbsy_s == ACTIVE) begin
               state_next = BUSY;
               bgout_next = NO_REQUEST;
            end else if (br_s[arb_owner] == INACTIVE) begin
               state_next = SETTLE;
               bgout_next = NO_REQUEST;
               cnt_next   = 8'd0;
            end else if (cnt == TIMEOUT_LAST) begin
               state_next   = SETTLE;
               bgout_next   = NO_REQUEST;
               cnt_next     = 8'd0;
               timeout_next = 1'b1;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         BUSY: begin
            if (bbsy_s == INACTIVE) begin
               state_next = SETTLE;
               cnt_next   = 8'd0;
            end else if (clear_req) begin
               state_next = CLEAR;
               bclr_next  = ACTIVE;
            end
         end
         CLEAR: begin
            if (bbsy_s == INACTIVE) begin
               state_next = SETTLE;
               bclr_next  = INACTIVE;
               cnt_next   = 8'd0;
            end
         end
         SETTLE: begin
            bgout_next = NO_REQUEST;
            bclr_next  = INACTIVE;
            if (cnt == SETTLE_LAST) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            bgout_next = NO_REQUEST;
            bclr_next  = INACTIVE;
            cnt_next   = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Directed testbench for vme_bus_arbiter (GRANT_TIMEOUT=8, SETTLE_CYCLES=2,
// SYNC_STAGES=2). Inputs change and outputs are sampled on the falling edge.
module tb_vme_bus_arbiter;

   import vme_arb_pkg::*;

   logic       clock;
   logic       reset;
   logic [3:0] vme_br;
   logic       vme_bbsy;
   logic [3:0] vme_bgout;
   logic       vme_bclr;
   logic [1:0] arb_owner;
   logic       arb_busy;
   logic       grant_timeout;

   int checks = 0;
   int passed = 0;

   vme_bus_arbiter #(
      .GRANT_TIMEOUT (8),
      .SETTLE_CYCLES (2),
      .SYNC_STAGES   (2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .vme_br        (vme_br),
      .vme_bbsy      (vme_bbsy),
      .vme_bgout     (vme_bgout),
      .vme_bclr      (vme_bclr),
      .arb_owner     (arb_owner),
      .arb_busy      (arb_busy),
      .grant_timeout (grant_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Drop every request and BBSY and wait long enough to be back in IDLE.
   task automatic release_bus();
      vme_br   = 4'b1111;
      vme_bbsy = 1'b1;
      step(12);
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      vme_br   = 4'b1111;
      vme_bbsy = 1'b1;
      #1;
      checks++; if (vme_bgout !== 4'b1111) $display("[TB] FAIL reset_bgout: got %b want %b", vme_bgout, 4'b1111); else passed++;
      checks++; if (vme_bclr !== 1'b1) $display("[TB] FAIL reset_bclr: got %b want 1", vme_bclr); else passed++;
      checks++; if (arb_owner !== 2'd0) $display("[TB] FAIL reset_owner: got %0d want 0", arb_owner); else passed++;
      checks++; if (arb_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", arb_busy); else passed++;
      checks++; if (grant_timeout !== 1'b0) $display("[TB] FAIL reset_timeout: got %b want 0", grant_timeout); else passed++;
      step(2);
      reset = 1'b0;
      step(3);
      checks++; if (arb_busy !== 1'b0) $display("[TB] FAIL idle_after_reset: busy got %b want 0", arb_busy); else passed++;
   endtask

   task automatic test_basic_grant();
      vme_br   = 4'b1110;
      vme_bbsy = 1'b1;
      step(2);
      checks++; if (vme_bgout !== 4'b1111) $display("[TB] FAIL grant_early: got %b want %b", vme_bgout, 4'b1111); else passed++;
      step(1);
      checks++; if (vme_bgout !== 4'b1110) $display("[TB] FAIL grant_l0: got %b want %b", vme_bgout, 4'b1110); else passed++;
      checks++; if (arb_owner !== 2'd0) $display("[TB] FAIL grant_owner: got %0d want 0", arb_owner); else passed++;
      checks++; if (arb_busy !== 1'b1) $display("[TB] FAIL grant_busy: got %b want 1", arb_busy); else passed++;
      vme_bbsy = 1'b0;
      step(2);
      checks++; if (vme_bgout !== 4'b1110) $display("[TB] FAIL grant_hold: got %b want %b", vme_bgout, 4'b1110); else passed++;
      step(1);
      checks++; if (vme_bgout !== 4'b1111) $display("[TB] FAIL busy_bgout: got %b want %b", vme_bgout, 4'b1111); else passed++;
      checks++; if (dut.state !== BUSY) $display("[TB] FAIL busy_state: got %0d want %0d", dut.state, BUSY); else passed++;
      vme_br   = 4'b1111;
      vme_bbsy = 1'b1;
      step(4);
      checks++; if (arb_busy !== 1'b1) $display("[TB] FAIL settle_busy: got %b want 1", arb_busy); else passed++;
      step(1);
      checks++; if (arb_busy !== 1'b0) $display("[TB] FAIL settle_done: got %b want 0", arb_busy); else passed++;
   endtask

   task automatic test_priority_clear();
      vme_br   = 4'b1110;
      vme_bbsy = 1'b1;
      step(3);
      vme_bbsy = 1'b0;
      step(3);
      checks++; if (dut.state !== BUSY) $display("[TB] FAIL pc_busy: got %0d want %0d", dut.state, BUSY); else passed++;
      vme_br = 4'b0110;
      step(2);
      checks++; if (vme_bclr !== 1'b1) $display("[TB] FAIL pc_bclr_early: got %b want 1", vme_bclr); else passed++;
      step(1);
`ifdef VME_ARB_ROUND_ROBIN_EN
      checks++; if (vme_bclr !== 1'b1) $display("[TB] FAIL rr_no_bclr: got %b want 1", vme_bclr); else passed++;
      checks++; if (dut.state !== BUSY) $display("[TB] FAIL rr_stay_busy: got %0d want %0d", dut.state, BUSY); else passed++;
      release_bus();
`else
      checks++; if (vme_bclr !== 1'b0) $display("[TB] FAIL pc_bclr: got %b want 0", vme_bclr); else passed++;
      checks++; if (vme_bgout !== 4'b1111) $display("[TB] FAIL pc_no_grant_with_bclr: got %b want %b", vme_bgout, 4'b1111); else passed++;
      vme_br = 4'b1110;
      step(4);
      checks++; if (vme_bclr !== 1'b0) $display("[TB] FAIL pc_bclr_held: got %b want 0", vme_bclr); else passed++;
      vme_br   = 4'b0111;
      vme_bbsy = 1'b1;
      step(3);
      checks++; if (vme_bclr !== 1'b1) $display("[TB] FAIL pc_bclr_release: got %b want 1", vme_bclr); else passed++;
      step(2);
      checks++; if (vme_bgout !== 4'b1111) $display("[TB] FAIL pc_settle_bgout: got %b want %b", vme_bgout, 4'b1111); else passed++;
      step(1);
      checks++; if (vme_bgout !== 4'b0111) $display("[TB] FAIL pc_grant_l3: got %b want %b", vme_bgout, 4'b0111); else passed++;
      checks++; if (arb_owner !== 2'd3) $display("[TB] FAIL pc_owner: got %0d want 3", arb_owner); else passed++;
      release_bus();
`endif
   endtask

   task automatic test_timeout();
      vme_br   = 4'b1011;
      vme_bbsy = 1'b1;
      step(3);
      checks++; if (vme_bgout !== 4'b1011) $display("[TB] FAIL to_grant: got %b want %b", vme_bgout, 4'b1011); else passed++;
      checks++; if (arb_owner !== 2'd2) $display("[TB] FAIL to_owner: got %0d want 2", arb_owner); else passed++;
      step(7);
      checks++; if (vme_bgout !== 4'b1011) $display("[TB] FAIL to_hold: got %b want %b", vme_bgout, 4'b1011); else passed++;
      checks++; if (grant_timeout !== 1'b0) $display("[TB] FAIL to_early_pulse: got %b want 0", grant_timeout); else passed++;
      step(1);
      checks++; if (vme_bgout !== 4'b1111) $display("[TB] FAIL to_withdraw: got %b want %b", vme_bgout, 4'b1111); else passed++;
      checks++; if (grant_timeout !== 1'b1) $display("[TB] FAIL to_pulse: got %b want 1", grant_timeout); else passed++;
      vme_br = 4'b1111;
      step(1);
      checks++; if (grant_timeout !== 1'b0) $display("[TB] FAIL to_pulse_width: got %b want 0", grant_timeout); else passed++;
      checks++; if (arb_busy !== 1'b1) $display("[TB] FAIL to_settle: got %b want 1", arb_busy); else passed++;
      step(1);
      checks++; if (arb_busy !== 1'b0) $display("[TB] FAIL to_idle: got %b want 0", arb_busy); else passed++;
   endtask

   task automatic test_withdrawn();
      vme_br   = 4'b1101;
      vme_bbsy = 1'b1;
      step(3);
      checks++; if (vme_bgout !== 4'b1101) $display("[TB] FAIL wd_grant: got %b want %b", vme_bgout, 4'b1101); else passed++;
      vme_br = 4'b1111;
      step(2);
      checks++; if (vme_bgout !== 4'b1101) $display("[TB] FAIL wd_hold: got %b want %b", vme_bgout, 4'b1101); else passed++;
      step(1);
      checks++; if (vme_bgout !== 4'b1111) $display("[TB] FAIL wd_release: got %b want %b", vme_bgout, 4'b1111); else passed++;
      checks++; if (grant_timeout !== 1'b0) $display("[TB] FAIL wd_no_pulse: got %b want 0", grant_timeout); else passed++;
      step(1);
      checks++; if (grant_timeout !== 1'b0) $display("[TB] FAIL wd_no_pulse2: got %b want 0", grant_timeout); else passed++;
      step(4);
   endtask

   task automatic test_reset_mid();
      vme_br   = 4'b1110;
      vme_bbsy = 1'b1;
      step(3);
      vme_bbsy = 1'b0;
      step(3);
      vme_br = 4'b0110;
      step(3);
`ifdef VME_ARB_ROUND_ROBIN_EN
      checks++; if (dut.state !== BUSY) $display("[TB] FAIL rm_state: got %0d want %0d", dut.state, BUSY); else passed++;
`else
      checks++; if (dut.state !== CLEAR) $display("[TB] FAIL rm_state: got %0d want %0d", dut.state, CLEAR); else passed++;
`endif
      #2;
      reset = 1'b1;
      #1;
      checks++; if (vme_bgout !== 4'b1111) $display("[TB] FAIL rm_bgout: got %b want %b", vme_bgout, 4'b1111); else passed++;
      checks++; if (vme_bclr !== 1'b1) $display("[TB] FAIL rm_bclr: got %b want 1", vme_bclr); else passed++;
      checks++; if (arb_busy !== 1'b0) $display("[TB] FAIL rm_busy: got %b want 0", arb_busy); else passed++;
      checks++; if (arb_owner !== 2'd0) $display("[TB] FAIL rm_owner: got %0d want 0", arb_owner); else passed++;
      vme_br   = 4'b1111;
      vme_bbsy = 1'b1;
      step(2);
      reset = 1'b0;
      step(3);
   endtask

   // Runs straight after a reset, so the round-robin search starts at level 3.
   task automatic test_simultaneous();
      logic [1:0] expected [5];
`ifdef VME_ARB_ROUND_ROBIN_EN
      expected = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
      expected = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
      for (int t = 0; t < 5; t++) begin
         logic [3:0] want;
         want = 4'b1111;
         want[expected[t]] = 1'b0;
         vme_br   = 4'b0000;
         vme_bbsy = 1'b1;
         step(3);
         checks++; if (vme_bgout !== want) $display("[TB] FAIL simul_grant[%0d]: got %b want %b", t, vme_bgout, want); else passed++;
         checks++; if (arb_owner !== expected[t]) $display("[TB] FAIL simul_owner[%0d]: got %0d want %0d", t, arb_owner, expected[t]); else passed++;
         vme_br = 4'b1111;
         step(8);
         checks++; if (arb_busy !== 1'b0) $display("[TB] FAIL simul_idle[%0d]: got %b want 0", t, arb_busy); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic_grant();
      test_priority_clear();
      test_timeout();
      test_withdrawn();
      test_reset_mid();
      test_simultaneous();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
